memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_pkg.sv | 24 ++
 rtl/memory_bus_arbiter_if.sv | 49 ++++
 rtl/memory_bus_arbiter_arb_rr_pick.sv | 24 ++
 rtl/memory_bus_arbiter.sv | 98 +++++++++
 tb/tb_memory_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] write_data;
        logic [3:0]  byte_enable;
        logic        write;
    } bus_req_t;

    function automatic logic other_master(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Request/response signals of both masters plus the shared memory bus.
interface memory_bus_arbiter_if;

    logic        m0_req;
    logic [31:0] m0_address;
    logic [31:0] m0_write_data;
    logic [3:0]  m0_byte_enable;
    logic        m0_write;
    logic        m0_ready;
    logic [31:0] m0_read_data;

    logic        m1_req;
    logic [31:0] m1_address;
    logic [31:0] m1_write_data;
    logic [3:0]  m1_byte_enable;
    logic        m1_write;
    logic        m1_ready;
    logic [31:0] m1_read_data;

    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;

    // Environment view: requesters and the memory behind the bus.
    modport master (
        output m0_req, m0_address, m0_write_data, m0_byte_enable, m0_write,
        input  m0_ready, m0_read_data,
        output m1_req, m1_address, m1_write_data, m1_byte_enable, m1_write,
        input  m1_ready, m1_read_data,
        input  bus_address, bus_write_data, bus_byte_enable,
        input  bus_read_enable, bus_write_enable,
        output bus_read_data
    );

    // Arbiter view.
    modport slave (
        input  m0_req, m0_address, m0_write_data, m0_byte_enable, m0_write,
        output m0_ready, m0_read_data,
        input  m1_req, m1_address, m1_write_data, m1_byte_enable, m1_write,
        output m1_ready, m1_read_data,
        output bus_address, bus_write_data, bus_byte_enable,
        output bus_read_enable, bus_write_enable,
        input  bus_read_data
    );

endinterface

// File: rtl/memory_bus_arbiter_arb_rr_pick.sv
// Combinational winner select for two requesters, round-robin or fixed priority.
// Zero latency; no backpressure, the caller decides when the pick is consumed.
module arb_rr_pick
    import memory_bus_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = MASTER_0;
        if (&req) begin
            winner = FAIR ? other_master(last) : MASTER_0;
        end else if (req[1]) begin
            winner = MASTER_1;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master memory bus arbiter: grant in IDLE, one bus cycle in ISSUE, ready 3 cycles after grant.
// Requesters hold req until their ready pulse; at most one bus transaction per 3 cycles.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    memory_bus_arbiter_if.slave  bus_if
);

    logic [1:0]          req;
    bus_req_t [1:0]      m_req;
    bus_req_t            win_req;
    logic                pick_idx;
    logic                pick_vld;

    arb_state_t          state;
    bus_req_t            lat;
    logic                lat_idx;
    logic                last_grant;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [1:0]          ready_q;
    logic [1:0][31:0]    read_data_q;

    assign req      = {bus_if.m1_req, bus_if.m0_req};
    assign m_req[0] = {bus_if.m0_address, bus_if.m0_write_data,
                       bus_if.m0_byte_enable, bus_if.m0_write};
    assign m_req[1] = {bus_if.m1_address, bus_if.m1_write_data,
                       bus_if.m1_byte_enable, bus_if.m1_write};
    assign win_req  = m_req[pick_idx];

    arb_rr_pick #(
        .FAIR (FAIR)
    ) u_pick (
        .req    (req),
        .last   (last_grant),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Enables and ready are registered pulses; everything else holds between grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat         <= '0;
            lat_idx     <= MASTER_0;
            last_grant  <= MASTER_1;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            ready_q     <= '0;
            read_data_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        lat        <= win_req;
                        lat_idx    <= pick_idx;
                        last_grant <= pick_idx;
                        rd_en_q    <= !win_req.write;
                        wr_en_q    <= win_req.write;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= COMPLETE;
                end
                COMPLETE: begin
                    if (!lat.write) begin
                        read_data_q[lat_idx] <= bus_if.bus_read_data;
                    end
                    ready_q[lat_idx] <= 1'b1;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.bus_address      = lat.address;
    assign bus_if.bus_write_data   = lat.write_data;
    assign bus_if.bus_byte_enable  = lat.byte_enable;
    assign bus_if.bus_read_enable  = rd_en_q;
    assign bus_if.bus_write_enable = wr_en_q;

    assign bus_if.m0_ready     = ready_q[0];
    assign bus_if.m1_ready     = ready_q[1];
    assign bus_if.m0_read_data = read_data_q[0];
    assign bus_if.m1_read_data = read_data_q[1];

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-schedule reference model.
module tb_memory_bus_arbiter;
    import memory_bus_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        wr    [2];
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [31:0] mem_a   [64];
    logic [31:0] mem_b   [64];
    logic [31:0] ref_mem [64];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    memory_bus_arbiter_if ifa ();
    memory_bus_arbiter_if ifb ();

    memory_bus_arbiter #(.FAIR(1'b1)) dut_a (.clock(clock), .reset(reset), .bus_if(ifa));
    memory_bus_arbiter #(.FAIR(1'b0)) dut_b (.clock(clock), .reset(reset), .bus_if(ifb));

    assign ifa.m0_req = req[0];        assign ifb.m0_req = req[0];
    assign ifa.m0_address = addr[0];   assign ifb.m0_address = addr[0];
    assign ifa.m0_write_data = wdata[0]; assign ifb.m0_write_data = wdata[0];
    assign ifa.m0_byte_enable = be[0]; assign ifb.m0_byte_enable = be[0];
    assign ifa.m0_write = wr[0];       assign ifb.m0_write = wr[0];
    assign ifa.m1_req = req[1];        assign ifb.m1_req = req[1];
    assign ifa.m1_address = addr[1];   assign ifb.m1_address = addr[1];
    assign ifa.m1_write_data = wdata[1]; assign ifb.m1_write_data = wdata[1];
    assign ifa.m1_byte_enable = be[1]; assign ifb.m1_byte_enable = be[1];
    assign ifa.m1_write = wr[1];       assign ifb.m1_write = wr[1];
    assign ifa.bus_read_data = rdata_a;
    assign ifb.bus_read_data = rdata_b;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the memory behind each bus answers a read in the following cycle.
    task automatic step();
        logic        ra, wa, rb, wb;
        logic [31:0] aa, ab, da, db;
        logic [3:0]  ba, bb;
        ra = ifa.bus_read_enable; wa = ifa.bus_write_enable;
        aa = ifa.bus_address; da = ifa.bus_write_data; ba = ifa.bus_byte_enable;
        rb = ifb.bus_read_enable; wb = ifb.bus_write_enable;
        ab = ifb.bus_address; db = ifb.bus_write_data; bb = ifb.bus_byte_enable;
        @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (wa && ba[k]) mem_a[aa[7:2]][8*k +: 8] = da[8*k +: 8];
            if (wb && bb[k]) mem_b[ab[7:2]][8*k +: 8] = db[8*k +: 8];
        end
        rdata_a = ra ? mem_a[aa[7:2]] : $urandom();
        rdata_b = rb ? mem_b[ab[7:2]] : $urandom();
        cyc++;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        mem_a[a[7:2]] = d;
        mem_b[a[7:2]] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w, last, e_w, e_wr;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
        logic [1:0]  act, rdy_obs;
        logic [31:0] mrd [2];
        int          iss_cyc, rdy_cyc, free_cyc;

        reset = 1'b1;
        req   = 2'b00;
        rdata_a = '0; rdata_b = '0;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; wdata[m] = '0; be[m] = 4'hF; wr[m] = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0; mem_b[i] = '0; ref_mem[i] = '0;
        end

        // Reset state
        step();
        step();
        chk1 ("rst_rd_en", ifa.bus_read_enable, 1'b0);
        chk1 ("rst_wr_en", ifa.bus_write_enable, 1'b0);
        chk32("rst_addr", ifa.bus_address, 32'h0);
        chk32("rst_wdata", ifa.bus_write_data, 32'h0);
        chk32("rst_be", 32'(ifa.bus_byte_enable), 32'h0);
        chk1 ("rst_rdy0", ifa.m0_ready, 1'b0);
        chk1 ("rst_rdy1", ifa.m1_ready, 1'b0);
        chk32("rst_rdata0", ifa.m0_read_data, 32'h0);
        chk32("rst_rdata1", ifa.m1_read_data, 32'h0);
        chk32("rst_state", 32'(dut_a.state), 32'(IDLE));
        reset = 1'b0;

        // m0 read of 0x10
        poke(32'h10, 32'hDEADBEEF);
        req[0] = 1'b1; addr[0] = 32'h10; wr[0] = 1'b0;
        step();
        chk1 ("s1_rd_en", ifa.bus_read_enable, 1'b1);
        chk1 ("s1_wr_en", ifa.bus_write_enable, 1'b0);
        chk32("s1_addr", ifa.bus_address, 32'h10);
        step();
        chk1 ("s1_rd_once", ifa.bus_read_enable, 1'b0);
        chk1 ("s1_rdy_early", ifa.m0_ready, 1'b0);
        step();
        chk1 ("s1_rdy0", ifa.m0_ready, 1'b1);
        chk1 ("s1_rdy1", ifa.m1_ready, 1'b0);
        chk32("s1_rdata0", ifa.m0_read_data, 32'hDEADBEEF);
        req[0] = 1'b0;
        step();
        chk1 ("s1_rdy_pulse", ifa.m0_ready, 1'b0);
        chk1 ("s1_no_reissue", ifa.bus_read_enable, 1'b0);
        chk32("s1_addr_hold", ifa.bus_address, 32'h10);

        // m1 write with partial byte lanes
        poke(32'h20, 32'hCAFEF00D);
        req[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h12345678; be[1] = 4'b0011; wr[1] = 1'b1;
        step();
        chk1 ("s2_wr_en", ifa.bus_write_enable, 1'b1);
        chk1 ("s2_rd_en", ifa.bus_read_enable, 1'b0);
        chk32("s2_addr", ifa.bus_address, 32'h20);
        chk32("s2_wdata", ifa.bus_write_data, 32'h12345678);
        chk32("s2_be", 32'(ifa.bus_byte_enable), 32'h3);
        step();
        chk1 ("s2_wr_once", ifa.bus_write_enable, 1'b0);
        step();
        chk1 ("s2_rdy1", ifa.m1_ready, 1'b1);
        chk1 ("s2_rdy0", ifa.m0_ready, 1'b0);
        chk32("s2_rdata0", ifa.m0_read_data, 32'hDEADBEEF);
        chk32("s2_rdata1", ifa.m1_read_data, 32'h0);
        req[1] = 1'b0;
        step();

        // Reads by each master land only in that master's read_data
        poke(32'h30, 32'hAAAAAAAA);
        poke(32'h34, 32'h55555555);
        req[0] = 1'b1; addr[0] = 32'h30; wr[0] = 1'b0;
        step(); step(); step();
        chk32("s5_rdata0", ifa.m0_read_data, 32'hAAAAAAAA);
        req[0] = 1'b0;
        req[1] = 1'b1; addr[1] = 32'h34; wr[1] = 1'b0;
        step(); step(); step();
        chk1 ("s5_rdy1", ifa.m1_ready, 1'b1);
        chk32("s5_rdata1", ifa.m1_read_data, 32'h55555555);
        chk32("s5_rdata0_keep", ifa.m0_read_data, 32'hAAAAAAAA);
        addr[1] = 32'h20;
        step(); step(); step();
        chk1 ("s5_b2b_rdy1", ifa.m1_ready, 1'b1);
        chk32("s5_merged", ifa.m1_read_data, 32'hCAFE5678);
        req[1] = 1'b0;
        step();

        // Continuous contention: FAIR alternates from m0, fixed priority always m0
        do_reset();
        req = 2'b11; addr[0] = 32'h40; addr[1] = 32'h44; wr[0] = 1'b0; wr[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk1("s3_a_rd_en", ifa.bus_read_enable, (k % 3) == 1);
            chk1("s3_a_rdy0", ifa.m0_ready, ((k % 3) == 0) && (((k / 3) % 2) == 1));
            chk1("s3_a_rdy1", ifa.m1_ready, ((k % 3) == 0) && (((k / 3) % 2) == 0));
            chk1("s3_b_rdy0", ifb.m0_ready, (k % 3) == 0);
            chk1("s3_b_rdy1", ifb.m1_ready, 1'b0);
        end
        req = 2'b00;
        step(); step(); step();

        // Reset during ISSUE
        do_reset();
        req[0] = 1'b1; addr[0] = 32'h50; wdata[0] = 32'h0BADF00D; be[0] = 4'hF; wr[0] = 1'b1;
        step();
        chk1("s4_wr_en", ifa.bus_write_enable, 1'b1);
        reset = 1'b1;
        req[0] = 1'b0;
        #1;
        chk1 ("s4_wr_async", ifa.bus_write_enable, 1'b0);
        chk1 ("s4_rd_async", ifa.bus_read_enable, 1'b0);
        chk32("s4_state", 32'(dut_a.state), 32'(IDLE));
        step();
        chk1("s4_no_rdy_a", ifa.m0_ready, 1'b0);
        step();
        chk1("s4_no_rdy_b", ifa.m0_ready, 1'b0);
        reset = 1'b0;
        step();
        chk1 ("s4_no_rdy_c", ifa.m0_ready, 1'b0);
        chk32("s4_idle", 32'(dut_a.state), 32'(IDLE));
        req[0] = 1'b1;
        step();
        chk1 ("s4_re_wr_en", ifa.bus_write_enable, 1'b1);
        chk32("s4_re_addr", ifa.bus_address, 32'h50);
        step(); step();
        chk1 ("s4_re_rdy", ifa.m0_ready, 1'b1);
        req[0] = 1'b0;
        step();

        // Randomized traffic against the schedule model (FAIR instance)
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom();
            mem_a[i] = v; mem_b[i] = v; ref_mem[i] = v;
        end
        do_reset();
        free_cyc = cyc; iss_cyc = -1; rdy_cyc = -1;
        last = 1'b1; e_w = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
        mrd[0] = '0; mrd[1] = '0; act = 2'b00;
        for (int i = 0; i < 10000; i++) begin
            rdy_obs = {ifa.m1_ready, ifa.m0_ready};
            if (cyc == rdy_cyc && !e_wr) mrd[e_w] = e_rdata;
            chk1("rnd_rd_en", ifa.bus_read_enable, (cyc == iss_cyc) && !e_wr);
            chk1("rnd_wr_en", ifa.bus_write_enable, (cyc == iss_cyc) && e_wr);
            chk1("rnd_excl", ifa.bus_read_enable & ifa.bus_write_enable, 1'b0);
            if (cyc == iss_cyc) begin
                chk32("rnd_addr", ifa.bus_address, e_addr);
                chk32("rnd_be", 32'(ifa.bus_byte_enable), 32'(e_be));
                if (e_wr) chk32("rnd_wdata", ifa.bus_write_data, e_wdata);
            end
            chk1 ("rnd_rdy0", ifa.m0_ready, (cyc == rdy_cyc) && (e_w == 1'b0));
            chk1 ("rnd_rdy1", ifa.m1_ready, (cyc == rdy_cyc) && (e_w == 1'b1));
            chk32("rnd_rdata0", ifa.m0_read_data, mrd[0]);
            chk32("rnd_rdata1", ifa.m1_read_data, mrd[1]);

            for (int m = 0; m < 2; m++) begin
                if (act[m] && rdy_obs[m]) act[m] = 1'b0;
                if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m]   = 1'b1;
                    addr[m]  = $urandom() & 32'hFFFF_FF3C;
                    wdata[m] = $urandom();
                    be[m]    = 4'($urandom_range(0, 15));
                    wr[m]    = 1'($urandom_range(0, 1));
                end
                req[m] = act[m];
            end

            // A grant occupies three cycles; the ready cycle may grant again.
            if (cyc >= free_cyc && req != 2'b00) begin
                w = (req == 2'b11) ? ~last : req[1];
                last = w; e_w = w;
                e_addr = addr[w]; e_wr = wr[w]; e_wdata = wdata[w]; e_be = be[w];
                if (e_wr) begin
                    for (int k = 0; k < 4; k++)
                        if (e_be[k]) ref_mem[e_addr[7:2]][8*k +: 8] = e_wdata[8*k +: 8];
                end else begin
                    e_rdata = ref_mem[e_addr[7:2]];
                end
                iss_cyc  = cyc + 1;
                rdy_cyc  = cyc + 3;
                free_cyc = cyc + 3;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
